// File: rtl/traffic_conflict_monitor_if.sv
`default_nettype none
// ============================================================================
// Module   : traffic_conflict_monitor_if
// Purpose  : Lamp/pedestrian inputs and fault outputs of the conflict monitor.
// Revision : 1.0 - initial release
// ============================================================================
interface traffic_conflict_monitor_if #(
  parameter int CNT_W = 8
);
  logic             enable;
  logic             tick_1s;
  logic [2:0]       road1_in;
  logic [2:0]       road2_in;
  logic [2:0]       ped1_in;
  logic [2:0]       ped2_in;
  logic             clear_fault;
  logic             fault;
  logic [2:0]       fault_code;
  logic             flash_req;
  logic [CNT_W-1:0] viol_cnt;

  // master: the side presenting lamp codes; slave: the monitor itself
  modport master (
    output enable, tick_1s, road1_in, road2_in, ped1_in, ped2_in, clear_fault,
    input  fault, fault_code, flash_req, viol_cnt
  );

  modport slave (
    input  enable, tick_1s, road1_in, road2_in, ped1_in, ped2_in, clear_fault,
    output fault, fault_code, flash_req, viol_cnt
  );
endinterface
`default_nettype wire

// File: rtl/traffic_conflict_monitor.sv
`default_nettype none
// ============================================================================
// Module   : traffic_conflict_monitor
// Purpose  : Watches lamp outputs, latches the first safety fault, requests flash.
// Revision : 1.0 - initial release
// ============================================================================
module traffic_conflict_monitor #(
  parameter int MIN_YELLOW = 3,
  parameter int MAX_GREEN  = 40,
  parameter int CNT_W      = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  traffic_conflict_monitor_if.slave mon
);

  localparam logic [2:0] c_lamp_r = 3'b100;
  localparam logic [2:0] c_lamp_y = 3'b010;
  localparam logic [2:0] c_lamp_g = 3'b001;
  localparam logic [2:0] c_ped_fl = 3'b010;
  localparam logic [2:0] c_ped_wk = 3'b001;

  localparam logic [2:0] c_code_none    = 3'd0;
  localparam logic [2:0] c_code_enc     = 3'd1;
  localparam logic [2:0] c_code_road    = 3'd2;
  localparam logic [2:0] c_code_ped     = 3'd3;
  localparam logic [2:0] c_code_seq     = 3'd4;
  localparam logic [2:0] c_code_yellow  = 3'd5;
  localparam logic [2:0] c_code_timeout = 3'd6;

  localparam logic [5:0]       c_min_yellow = 6'(MIN_YELLOW);
  localparam logic [5:0]       c_max_green  = 6'(MAX_GREEN);
  localparam logic [5:0]       c_tmr_max    = 6'd63;
  localparam logic [CNT_W-1:0] c_cnt_max    = '1;
  localparam logic [CNT_W-1:0] c_cnt_one    = CNT_W'(1);

  function automatic logic f_onehot(input logic [2:0] v);
    return (v == 3'b100) || (v == 3'b010) || (v == 3'b001);
  endfunction

  logic [1:0]       w_road_ok;
  logic [1:0]       w_ped_ok;
  logic [1:0]       w_not_red;
  logic [1:0]       w_ped_bad;
  logic [1:0]       w_seq_bad;
  logic [1:0]       w_short_yel;
  logic [1:0]       w_timeout;
  logic [2:0]       w_code;

  logic             r_fault;
  logic [2:0]       r_fault_code;
  logic [CNT_W-1:0] r_viol_cnt;

  // Per-road checks, previous-value register and dwell timer
  for (genvar gi = 0; gi < 2; gi++) begin : g_road
    logic [2:0] w_lamp;
    logic [2:0] w_ped;
    logic [2:0] r_prev_lamp;
    logic [5:0] r_tmr;

    assign w_lamp = (gi == 0) ? mon.road1_in : mon.road2_in;
    assign w_ped  = (gi == 0) ? mon.ped1_in  : mon.ped2_in;

    assign w_road_ok[gi] = f_onehot(w_lamp);
    assign w_ped_ok[gi]  = f_onehot(w_ped);
    assign w_not_red[gi] = (w_lamp != c_lamp_r);
    assign w_ped_bad[gi] = ((w_ped == c_ped_wk) || (w_ped == c_ped_fl)) && w_not_red[gi];

    // Only legal one-hot pairs can match these patterns, so no extra qualifier
    assign w_seq_bad[gi] = ((r_prev_lamp == c_lamp_g) && (w_lamp == c_lamp_r)) ||
                           ((r_prev_lamp == c_lamp_y) && (w_lamp == c_lamp_g)) ||
                           ((r_prev_lamp == c_lamp_r) && (w_lamp == c_lamp_y));

    assign w_short_yel[gi] = (r_prev_lamp == c_lamp_y) && (w_lamp == c_lamp_r) &&
                             (r_tmr < c_min_yellow);

    assign w_timeout[gi] = mon.tick_1s && (r_prev_lamp == c_lamp_g) &&
                           (w_lamp == c_lamp_g) && (r_tmr == c_max_green);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_prev_lamp <= c_lamp_r;
        r_tmr       <= 6'd0;
      end else begin
        r_prev_lamp <= w_lamp;
        if (w_lamp != r_prev_lamp) begin
          r_tmr <= 6'd0;
        end else if (mon.enable && mon.tick_1s && (r_tmr != c_tmr_max)) begin
          r_tmr <= r_tmr + 6'd1;
        end
      end
    end
  end

  // Lowest code wins when several rules fire together
  always_comb begin
    w_code = c_code_none;
    if (!((&w_road_ok) && (&w_ped_ok))) begin
      w_code = c_code_enc;
    end else if (&w_not_red) begin
      w_code = c_code_road;
    end else if (|w_ped_bad) begin
      w_code = c_code_ped;
    end else if (|w_seq_bad) begin
      w_code = c_code_seq;
    end else if (|w_short_yel) begin
      w_code = c_code_yellow;
    end else if (|w_timeout) begin
      w_code = c_code_timeout;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fault      <= 1'b0;
      r_fault_code <= c_code_none;
      r_viol_cnt   <= '0;
    end else if (mon.enable) begin
      if (w_code != c_code_none) begin
        // A clear coinciding with a violation re-arms onto the new code
        if (!r_fault || mon.clear_fault) begin
          r_fault      <= 1'b1;
          r_fault_code <= w_code;
        end
        if (r_viol_cnt != c_cnt_max) begin
          r_viol_cnt <= r_viol_cnt + c_cnt_one;
        end
      end else if (mon.clear_fault) begin
        r_fault      <= 1'b0;
        r_fault_code <= c_code_none;
      end
    end
  end

  assign mon.fault      = r_fault;
  assign mon.fault_code = r_fault_code;
  assign mon.flash_req  = r_fault;
  assign mon.viol_cnt   = r_viol_cnt;

endmodule
`default_nettype wire

// File: tb/tb_traffic_conflict_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_traffic_conflict_monitor
// Purpose  : Scoreboarded directed + random bench for traffic_conflict_monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_traffic_conflict_monitor;

  localparam int MIN_YELLOW = 3;
  localparam int MAX_GREEN  = 40;
  localparam int CNT_W      = 8;

  localparam logic [2:0] R  = 3'b100;
  localparam logic [2:0] Y  = 3'b010;
  localparam logic [2:0] G  = 3'b001;
  localparam logic [2:0] DW = 3'b100;
  localparam logic [2:0] FL = 3'b010;
  localparam logic [2:0] WK = 3'b001;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  traffic_conflict_monitor_if #(.CNT_W(CNT_W)) mon_if ();

  traffic_conflict_monitor #(
    .MIN_YELLOW(MIN_YELLOW),
    .MAX_GREEN (MAX_GREEN),
    .CNT_W     (CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mon(mon_if)
  );

  typedef struct packed {
    logic             fault;
    logic [2:0]       code;
    logic             flash;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model state
  logic [2:0] m_prev [2];
  int         m_tmr  [2];
  bit         m_fault;
  int         m_code;
  int         m_cnt;

  // Lamp class: 0=R/DW, 1=Y/FL, 2=G/WK, -1=not one-hot
  function automatic int cls(input logic [2:0] v);
    case (v)
      3'b100:  return 0;
      3'b010:  return 1;
      3'b001:  return 2;
      default: return -1;
    endcase
  endfunction

  // Legal road cycle R -> G -> Y -> R
  function automatic int succ(input int c);
    case (c)
      0:       return 2;
      2:       return 1;
      default: return 0;
    endcase
  endfunction

  function automatic exp_t snapshot();
    exp_t e;
    e.fault = m_fault;
    e.code  = 3'(m_code);
    e.flash = m_fault;
    e.cnt   = CNT_W'(m_cnt);
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_prev[i] = R;
      m_tmr[i]  = 0;
    end
    m_fault = 1'b0;
    m_code  = 0;
    m_cnt   = 0;
  endtask

  task automatic model_step(input bit en, input bit tk, input logic [2:0] r1, input logic [2:0] r2,
                            input logic [2:0] p1, input logic [2:0] p2, input bit clr);
    logic [2:0] cur [2];
    int rc [2];
    int pc [2];
    int pr [2];
    int code;
    bit b4, b5, b6;
    cur[0] = r1;
    cur[1] = r2;
    pc[0]  = cls(p1);
    pc[1]  = cls(p2);
    for (int i = 0; i < 2; i++) begin
      rc[i] = cls(cur[i]);
      pr[i] = cls(m_prev[i]);
    end
    code = 0;
    b4 = 1'b0; b5 = 1'b0; b6 = 1'b0;
    if (rc[0] < 0 || rc[1] < 0 || pc[0] < 0 || pc[1] < 0) code = 1;
    else if (rc[0] != 0 && rc[1] != 0) code = 2;
    else if ((pc[0] != 0 && rc[0] != 0) || (pc[1] != 0 && rc[1] != 0)) code = 3;
    else begin
      for (int i = 0; i < 2; i++) begin
        if (pr[i] >= 0 && rc[i] != pr[i] && rc[i] != succ(pr[i])) b4 = 1'b1;
        if (pr[i] == 1 && rc[i] == 0 && m_tmr[i] < MIN_YELLOW) b5 = 1'b1;
        if (tk && pr[i] == 2 && rc[i] == 2 && m_tmr[i] == MAX_GREEN) b6 = 1'b1;
      end
      code = b4 ? 4 : (b5 ? 5 : (b6 ? 6 : 0));
    end
    if (en && code != 0) begin
      if (!m_fault || clr) begin
        m_fault = 1'b1;
        m_code  = code;
      end
      if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
    end else if (en && clr) begin
      m_fault = 1'b0;
      m_code  = 0;
    end
    for (int i = 0; i < 2; i++) begin
      if (cur[i] !== m_prev[i]) m_tmr[i] = 0;
      else if (en && tk && m_tmr[i] < 63) m_tmr[i]++;
      m_prev[i] = cur[i];
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Scoreboard monitor: one expected entry per sampled edge
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      exp_t a;
      e = exp_q.pop_front();
      a = {mon_if.fault, mon_if.fault_code, mon_if.flash_req, mon_if.viol_cnt};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL scoreboard t=%0t actual fault=%b code=%0d flash=%b cnt=%0d required fault=%b code=%0d flash=%b cnt=%0d",
                 $time, a.fault, a.code, a.flash, a.cnt, e.fault, e.code, e.flash, e.cnt);
      end
    end
  end

  task automatic drive(input bit en, input bit tk, input logic [2:0] r1, input logic [2:0] r2,
                       input logic [2:0] p1, input logic [2:0] p2, input bit clr);
    mon_if.enable      = en;
    mon_if.tick_1s     = tk;
    mon_if.road1_in    = r1;
    mon_if.road2_in    = r2;
    mon_if.ped1_in     = p1;
    mon_if.ped2_in     = p2;
    mon_if.clear_fault = clr;
  endtask

  task automatic step(input bit en, input bit tk, input logic [2:0] r1, input logic [2:0] r2,
                      input logic [2:0] p1, input logic [2:0] p2, input bit clr);
    @(negedge clk);
    drive(en, tk, r1, r2, p1, p2, clr);
    model_step(en, tk, r1, r2, p1, p2, clr);
    exp_q.push_back(snapshot());
    @(posedge clk);
    #2;
  endtask

  task automatic drive1(input bit tk, input logic [2:0] r1, input bit clr);
    step(1'b1, tk, r1, R, DW, DW, clr);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 1'b0, R, R, DW, DW, 1'b0);
    #1;
    check("rst_fault", 32'(mon_if.fault), 0);
    check("rst_code",  32'(mon_if.fault_code), 0);
    check("rst_flash", 32'(mon_if.flash_req), 0);
    check("rst_cnt",   32'(mon_if.viol_cnt), 0);
    model_reset();
    exp_q.push_back(snapshot());
    @(posedge clk);
    #2;
    @(negedge clk);
    rst = 1'b0;
    model_step(1'b1, 1'b0, R, R, DW, DW, 1'b0);
    exp_q.push_back(snapshot());
    @(posedge clk);
    #2;
  endtask

  function automatic logic [2:0] next_lamp(input logic [2:0] v);
    case (v)
      3'b100:  return 3'b001;
      3'b001:  return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  function automatic logic [2:0] rand_road(input logic [2:0] v);
    int r;
    r = int'($urandom_range(0, 99));
    if (r < 70) return v;
    if (r < 93) return next_lamp(v);
    return 3'($urandom_range(0, 7));
  endfunction

  function automatic logic [2:0] rand_ped(input logic [2:0] v);
    int r;
    r = int'($urandom_range(0, 99));
    if (r < 80) return v;
    if (r < 90) return DW;
    if (r < 94) return FL;
    if (r < 98) return WK;
    return 3'($urandom_range(0, 7));
  endfunction

  initial begin
    logic [2:0] cr1, cr2, cp1, cp2;
    bit en, tk, clr;
    rst = 1'b1;
    drive(1'b1, 1'b0, R, R, DW, DW, 1'b0);
    model_reset();

    // Legal road1 cycle
    do_reset();
    drive1(1'b0, G, 1'b0);
    repeat (10) drive1(1'b1, G, 1'b0);
    drive1(1'b0, Y, 1'b0);
    repeat (3) drive1(1'b1, Y, 1'b0);
    drive1(1'b0, R, 1'b0);
    check("legal_fault", 32'(mon_if.fault), 0);
    check("legal_cnt",   32'(mon_if.viol_cnt), 0);

    // Conflicting greens
    do_reset();
    step(1'b1, 1'b0, G, G, DW, DW, 1'b0);
    check("conf_fault", 32'(mon_if.fault), 1);
    check("conf_code",  32'(mon_if.fault_code), 2);
    check("conf_flash", 32'(mon_if.flash_req), 1);
    check("conf_cnt",   32'(mon_if.viol_cnt), 1);

    // Encoding beats conflict; first fault holds
    do_reset();
    step(1'b1, 1'b0, 3'b011, G, DW, DW, 1'b0);
    check("prio_code", 32'(mon_if.fault_code), 1);
    step(1'b1, 1'b0, G, G, DW, DW, 1'b0);
    check("prio_hold_code", 32'(mon_if.fault_code), 1);
    check("prio_cnt",       32'(mon_if.viol_cnt), 2);

    // Sequence, short yellow, green timeout
    do_reset();
    drive1(1'b0, G, 1'b0);
    drive1(1'b0, R, 1'b0);
    check("seq_code", 32'(mon_if.fault_code), 4);
    drive1(1'b0, R, 1'b1);
    check("seq_clear", 32'(mon_if.fault), 0);
    drive1(1'b0, G, 1'b0);
    drive1(1'b0, Y, 1'b0);
    repeat (2) drive1(1'b1, Y, 1'b0);
    drive1(1'b0, R, 1'b0);
    check("short_yel_code", 32'(mon_if.fault_code), 5);
    drive1(1'b0, R, 1'b1);
    drive1(1'b0, G, 1'b0);
    repeat (40) drive1(1'b1, G, 1'b0);
    check("pre_timeout_fault", 32'(mon_if.fault), 0);
    drive1(1'b1, G, 1'b0);
    check("timeout_code", 32'(mon_if.fault_code), 6);

    // Ped conflict and clear behaviour
    do_reset();
    step(1'b1, 1'b0, G, R, WK, DW, 1'b0);
    check("ped_code", 32'(mon_if.fault_code), 3);
    step(1'b1, 1'b0, G, R, DW, DW, 1'b1);
    check("clr_fault", 32'(mon_if.fault), 0);
    check("clr_code",  32'(mon_if.fault_code), 0);
    step(1'b1, 1'b0, G, G, DW, DW, 1'b1);
    check("clr_viol_fault", 32'(mon_if.fault), 1);
    check("clr_viol_code",  32'(mon_if.fault_code), 2);

    // Disabled illegal move, then re-enable on stable red
    do_reset();
    drive1(1'b0, G, 1'b0);
    step(1'b0, 1'b0, R, R, DW, DW, 1'b0);
    check("dis_fault", 32'(mon_if.fault), 0);
    drive1(1'b0, R, 1'b0);
    check("reen_fault", 32'(mon_if.fault), 0);

    // Reset in the middle of yellow with a latched fault
    do_reset();
    step(1'b1, 1'b0, G, R, WK, DW, 1'b0);
    step(1'b1, 1'b0, G, R, DW, DW, 1'b0);
    drive1(1'b0, Y, 1'b0);
    drive1(1'b1, Y, 1'b0);
    check("pre_rst_fault", 32'(mon_if.fault), 1);
    do_reset();

    // Random traffic against the reference model
    cr1 = R; cr2 = R; cp1 = DW; cp2 = DW;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
        cr1 = R; cr2 = R; cp1 = DW; cp2 = DW;
      end else begin
        cr1 = rand_road(cr1);
        cr2 = rand_road(cr2);
        cp1 = rand_ped(cp1);
        cp2 = rand_ped(cp2);
        tk  = ($urandom_range(0, 3) == 0);
        en  = ($urandom_range(0, 9) != 0);
        clr = ($urandom_range(0, 15) == 0);
        step(en, tk, cr1, cr2, cp1, cp2, clr);
      end
    end

    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d required=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
